// File: rtl/fp_pkg.sv
// Shared constants, state encoding and result helpers for the single-precision
// adder back end (add/subtract, normalize, round, pack).
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int GRS_W   = 3;
  // Bit MANT_W-1 is carry headroom, bit MANT_W-2 is the hidden one.
  localparam int MANT_W  = FRAC_W + GRS_W + 2;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // FSM encoding kept as plain constants so older blocks can share it.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ADD   = 3'd1;
  localparam state_t S_NORM  = 3'd2;
  localparam state_t S_ROUND = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  localparam logic [31:0] RES_ZERO = 32'h0000_0000;

  // Signed infinity in packed form.
  function automatic logic [31:0] res_inf(input logic sign);
    return {sign, 8'hFF, 23'h0};
  endfunction

endpackage

// File: rtl/fp_add_normalize_if.sv
// Operand/result handshake bundle between the sign stage, this block and the
// result consumer.
interface fp_add_normalize_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] aa;
  logic [MANT_W-1:0] bb;
  logic              as_op;
  logic              so_in;
  logic [EXP_W-1:0]  exp_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, aa, bb, as_op, so_in, exp_in, out_ready,
    input  in_ready, out_valid, result
  );

  // Adder side.
  modport slave (
    input  in_valid, aa, bb, as_op, so_in, exp_in, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized magnitude, with renormalization when
// the increment carries into the headroom bit and an overflow flag.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mag_in,
  input  logic [EXP_W:0]    exp_in,
  output logic [MANT_W-1:0] mag_out,
  output logic [EXP_W:0]    exp_out,
  output logic              ovf
);

  logic              round_up;
  logic [MANT_W-1:0] sum;

  // Increment at the LSB when above half, or exactly half with an odd LSB.
  always_comb begin
    round_up = mag_in[GRS_W-1] & (mag_in[GRS_W-2] | mag_in[GRS_W-3] | mag_in[GRS_W]);
    sum      = mag_in + {{(MANT_W-GRS_W-1){1'b0}}, round_up, {GRS_W{1'b0}}};
    if (sum[MANT_W-1]) begin
      mag_out = sum >> 1;
      exp_out = exp_in + 1'b1;
    end else begin
      mag_out = sum;
      exp_out = exp_in;
    end
    ovf = (exp_out >= (EXP_W+1)'(EXP_MAX));
  end

endmodule

// File: rtl/fp_add_normalize.sv
// Adds or subtracts aligned mantissas, normalizes one left shift per cycle,
// rounds to nearest even and packs a single-precision result.
module fp_add_normalize
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fp_add_normalize_if.slave   bus
);

  state_t            state_reg;
  logic [MANT_W-1:0] aa_reg;
  logic [MANT_W-1:0] bb_reg;
  logic              as_op_reg;
  logic              so_reg;
  logic [MANT_W-1:0] mag_reg;
  logic [EXP_W:0]    exp_reg;   // one spare bit so the overflow test cannot wrap
  logic              sign_reg;
  logic [31:0]       result_reg;

  logic [MANT_W:0]   diff;
  logic              borrow;
  logic [MANT_W-1:0] abs_diff;
  logic [MANT_W-1:0] sum;
  logic [MANT_W-1:0] rnd_mag;
  logic [EXP_W:0]    rnd_exp;
  logic              rnd_ovf;

  // Add path and magnitude of the subtract; the borrow gives the result sign.
  always_comb begin
    sum      = aa_reg + bb_reg;
    diff     = {1'b0, aa_reg} - {1'b0, bb_reg};
    borrow   = diff[MANT_W];
    abs_diff = borrow ? (bb_reg - aa_reg) : diff[MANT_W-1:0];
  end

  fp_round_rne u_round (
    .mag_in  (mag_reg),
    .exp_in  (exp_reg),
    .mag_out (rnd_mag),
    .exp_out (rnd_exp),
    .ovf     (rnd_ovf)
  );

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.result    = result_reg;

  // Control FSM and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      aa_reg     <= '0;
      bb_reg     <= '0;
      as_op_reg  <= 1'b0;
      so_reg     <= 1'b0;
      mag_reg    <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      result_reg <= RES_ZERO;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            aa_reg    <= bus.aa;
            bb_reg    <= bus.bb;
            as_op_reg <= bus.as_op;
            so_reg    <= bus.so_in;
            exp_reg   <= {1'b0, bus.exp_in};
            state_reg <= S_ADD;
          end
        end
        S_ADD: begin
          if (as_op_reg) begin
            mag_reg  <= abs_diff;
            sign_reg <= borrow;
          end else begin
            mag_reg  <= sum;
            sign_reg <= so_reg;
          end
          state_reg <= S_NORM;
        end
        S_NORM: begin
          if (mag_reg == '0) begin
            result_reg <= RES_ZERO;
            state_reg  <= S_DONE;
          end else if (mag_reg[MANT_W-1]) begin
            // Keep the dropped bit alive in the sticky position.
            mag_reg   <= {1'b0, mag_reg[MANT_W-1:2], mag_reg[1] | mag_reg[0]};
            exp_reg   <= exp_reg + 1'b1;
            state_reg <= S_ROUND;
          end else if (mag_reg[MANT_W-2]) begin
            state_reg <= S_ROUND;
          end else if (exp_reg == (EXP_W+1)'(1)) begin
            // Subnormals are not produced; flush to signed zero.
            result_reg <= {sign_reg, 31'h0};
            state_reg  <= S_DONE;
          end else begin
            mag_reg <= mag_reg << 1;
            exp_reg <= exp_reg - 1'b1;
          end
        end
        S_ROUND: begin
          mag_reg <= rnd_mag;
          exp_reg <= rnd_exp;
          if (rnd_ovf) begin
            result_reg <= res_inf(sign_reg);
          end else begin
            result_reg <= {sign_reg, rnd_exp[EXP_W-1:0], rnd_mag[MANT_W-3:GRS_W]};
          end
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed-vector bench for fp_add_normalize: result, latency, handshake,
// backpressure and mid-operation reset.
module tb_fp_add_normalize;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_add_normalize_if bus ();

  fp_add_normalize dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One operation: present operands, wait for the result (bounded), optionally
  // hold off the consumer for 'hold' cycles, then accept.
  task automatic run_op(input string tag, input logic [27:0] a, input logic [27:0] b,
                        input logic op, input logic so, input logic [7:0] e,
                        input logic [31:0] want, input int want_lat, input int hold);
    int lat;
    @(negedge clk);
    bus.aa = a; bus.bb = b; bus.as_op = op; bus.so_in = so; bus.exp_in = e;
    bus.in_valid = 1'b1;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " result"}, bus.result, want);
    check({tag, " latency"}, 32'(lat), 32'(want_lat));
    for (int i = 0; i < hold; i++) begin
      // A competing bundle must not be taken while the result is pending.
      bus.in_valid = 1'b1;
      bus.aa = 28'h1234567;
      @(posedge clk); #1;
      check({tag, " hold result"}, bus.result, want);
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " post out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(bus.in_ready), 32'd1);
    $display("[TB] %s: result=%h latency=%0d", tag, bus.result, lat);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.aa = '0; bus.bb = '0; bus.as_op = 1'b0; bus.so_in = 1'b0; bus.exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_op("1.0+1.0",     28'h4000000, 28'h4000000, 1'b0, 1'b0, 8'd127, 32'h40000000, 3, 0);
    run_op("1.5-1.0",     28'h6000000, 28'h4000000, 1'b1, 1'b0, 8'd127, 32'h3F000000, 4, 0);
    run_op("1.0-1.5",     28'h4000000, 28'h6000000, 1'b1, 1'b0, 8'd127, 32'hBF000000, 4, 0);
    run_op("cancel",      28'h5000000, 28'h5000000, 1'b1, 1'b0, 8'd127, 32'h00000000, 2, 0);
    run_op("rne carry",   28'h7FFFFFC, 28'h0000000, 1'b0, 1'b0, 8'd127, 32'h40000000, 3, 0);
    run_op("overflow",    28'h4000000, 28'h4000000, 1'b0, 1'b0, 8'd254, 32'h7F800000, 3, 0);
    run_op("tie even",    28'h4000004, 28'h0000000, 1'b0, 1'b0, 8'd127, 32'h3F800000, 3, 0);
    run_op("tie odd up",  28'h400000C, 28'h0000000, 1'b0, 1'b0, 8'd127, 32'h3F800002, 3, 0);
    run_op("flush",       28'h2000000, 28'h0000000, 1'b0, 1'b1, 8'd1,   32'h80000000, 2, 0);
    run_op("min normal",  28'h2000000, 28'h0000000, 1'b0, 1'b0, 8'd2,   32'h00800000, 4, 0);
    run_op("26 shifts",   28'h4000000, 28'h3FFFFFF, 1'b1, 1'b0, 8'd127, 32'h32800000, 29, 0);
    run_op("backpressure",28'h4000000, 28'h4000000, 1'b0, 1'b1, 8'd127, 32'hC0000000, 3, 5);

    // Abort a long normalization with reset; nothing may come out afterwards.
    @(negedge clk);
    bus.aa = 28'h4000000; bus.bb = 28'h3FFFFFF; bus.as_op = 1'b1; bus.exp_in = 8'd127;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid = 1;
    end
    check("abort no result", 32'(seen_valid), 32'd0);
    check("abort idle", 32'(bus.in_ready), 32'd1);
    $display("[TB] reset abort: out_valid_seen=%0d", seen_valid);

    run_op("after reset", 28'h6000000, 28'h4000000, 1'b1, 1'b0, 8'd127, 32'h3F000000, 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
